// File: rtl/mos_gate_guard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mos_gate_guard_pkg
// Purpose : Shared definitions for the gate guard. Gate codes use the per-leg
//           {upper,lower} packing. Also holds the leg/deion state encodings,
//           the leg index constants and a state-to-gate decode helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package mos_gate_guard_pkg;

    localparam logic [1:0] GATE_OFF     = 2'b00;
    localparam logic [1:0] GATE_UP      = 2'b10;
    localparam logic [1:0] GATE_LO      = 2'b01;
    localparam logic [1:0] GATE_ILLEGAL = 2'b11;

    localparam int NUM_LEGS  = 4;
    localparam int LEG_BUCK1 = 3;
    localparam int LEG_BUCK2 = 2;
    localparam int LEG_RES1  = 1;
    localparam int LEG_RES2  = 0;

    typedef enum logic [1:0] {
        LEG_OFF   = 2'd0,
        LEG_UP_ON = 2'd1,
        LEG_LO_ON = 2'd2
    } leg_state_t;

    typedef enum logic {
        DEION_OFF = 1'b0,
        DEION_ON  = 1'b1
    } deion_state_t;

    function automatic logic [1:0] leg_gate_code(input leg_state_t s);
        case (s)
            LEG_UP_ON: return GATE_UP;
            LEG_LO_ON: return GATE_LO;
            default:   return GATE_OFF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mos_gate_guard_if.sv
`default_nettype none
// ============================================================================
// Module  : mos_gate_guard_if
// Purpose : Request/response bundle between the discharge controller
//           (master) and the gate guard (slave).
// Signals : gate_en, leg_req[7:0], deion_req, fault_clear  (master -> slave)
//           leg_gate[7:0], deion_gate, fault, fault_leg[3:0],
//           stretch_cnt[15:0]                              (slave -> master)
// Rev     : 1.0  initial release
// ============================================================================
interface mos_gate_guard_if;
    logic        gate_en;
    logic [7:0]  leg_req;
    logic        deion_req;
    logic        fault_clear;
    logic [7:0]  leg_gate;
    logic        deion_gate;
    logic        fault;
    logic [3:0]  fault_leg;
    logic [15:0] stretch_cnt;

    modport master (
        output gate_en, leg_req, deion_req, fault_clear,
        input  leg_gate, deion_gate, fault, fault_leg, stretch_cnt
    );

    modport slave (
        input  gate_en, leg_req, deion_req, fault_clear,
        output leg_gate, deion_gate, fault, fault_leg, stretch_cnt
    );
endinterface
`default_nettype wire

// File: rtl/gate_leg_guard.sv
`default_nettype none
// ============================================================================
// Module  : gate_leg_guard
// Purpose : One half-bridge leg. OFF/UP_ON/LO_ON state machine that enforces
//           dead time before turn-on and minimum on time before turn-off.
//           It also flags the first cycle each new request is held back.
// Ports   : clk, rst      clock, synchronous active-high reset
//           req[1:0]      requested {upper,lower}
//           kill          force OFF next cycle, ignoring minimum on time
//           restart       restart the dead-time count from zero
//           gate[1:0]     registered gate drive
//           stretch       one-cycle pulse: a new request edge was delayed
// Rev     : 1.0  initial release
// ============================================================================
module gate_leg_guard
    import mos_gate_guard_pkg::*;
#(
    parameter logic [15:0] DEAD_TIME = 16'd10,
    parameter logic [15:0] MIN_ON    = 16'd5,
    parameter int          CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       kill,
    input  logic       restart,
    output logic [1:0] gate,
    output logic       stretch
);

    localparam logic [CNT_W-1:0] c_dead_m1   = CNT_W'(DEAD_TIME - 16'd1);
    localparam logic [CNT_W-1:0] c_min_on_m1 = CNT_W'(MIN_ON - 16'd1);
    localparam logic [CNT_W-1:0] c_cnt_max   = '1;

    leg_state_t       r_state, w_state_nxt;
    // One counter serves as off_cnt in OFF and on_cnt in the ON states; it
    // clears whenever the state changes.
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_gate;
    logic [1:0]       r_prev_req;
    logic             r_counted;
    logic             w_want, w_grant, w_new_edge, w_stretch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LEG_OFF;
            r_cnt      <= c_cnt_max;
            r_gate     <= GATE_OFF;
            r_prev_req <= GATE_OFF;
            r_counted  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gate     <= leg_gate_code(w_state_nxt);
            r_prev_req <= req;
            // r_counted marks that the current request value was already
            // counted as stretched; any change of request re-arms it.
            r_counted  <= (w_new_edge ? 1'b0 : r_counted) | w_stretch;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_want      = 1'b0;
        w_grant     = 1'b0;
        case (r_state)
            LEG_OFF: begin
                w_want  = (req == GATE_UP) || (req == GATE_LO);
                w_grant = w_want && (r_cnt >= c_dead_m1);
                if (w_grant) begin
                    w_state_nxt = (req == GATE_UP) ? LEG_UP_ON : LEG_LO_ON;
                end
            end
            LEG_UP_ON: begin
                w_want  = (req != GATE_UP);
                w_grant = w_want && (r_cnt >= c_min_on_m1);
                if (w_grant) w_state_nxt = LEG_OFF;
            end
            LEG_LO_ON: begin
                w_want  = (req != GATE_LO);
                w_grant = w_want && (r_cnt >= c_min_on_m1);
                if (w_grant) w_state_nxt = LEG_OFF;
            end
            default: w_state_nxt = LEG_OFF;
        endcase
        if (kill) w_state_nxt = LEG_OFF;

        w_cnt_nxt = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;
        if ((w_state_nxt != r_state) || restart) w_cnt_nxt = '0;

        w_new_edge = (req != r_prev_req);
        w_stretch  = w_want && !w_grant && !kill && (w_new_edge || !r_counted);
    end

    assign gate    = r_gate;
    assign stretch = w_stretch;

endmodule
`default_nettype wire

// File: rtl/mos_gate_guard.sv
`default_nettype none
// ============================================================================
// Module  : mos_gate_guard
// Purpose : Final guard in front of the gate drivers. Four leg guards plus the
//           deion switch interlock. It latches a fault on a 2'b11 request and
//           counts delayed requests.
// Ports   : clk, rst      clock, synchronous active-high reset
//           bus (slave)   gate_en, leg_req, deion_req, fault_clear in;
//                         leg_gate, deion_gate, fault, fault_leg, stretch_cnt out
// Rev     : 1.0  initial release
// ============================================================================
module mos_gate_guard
    import mos_gate_guard_pkg::*;
#(
    parameter logic [15:0] DEAD_TIME = 16'd10,
    parameter logic [15:0] MIN_ON    = 16'd5,
    parameter logic [15:0] MIN_OFF   = 16'd5,
    parameter int          CNT_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    mos_gate_guard_if.slave bus
);

    localparam logic [CNT_W-1:0] c_min_on_m1  = CNT_W'(MIN_ON - 16'd1);
    localparam logic [CNT_W-1:0] c_min_off_m1 = CNT_W'(MIN_OFF - 16'd1);
    localparam logic [CNT_W-1:0] c_cnt_max    = '1;

    logic [NUM_LEGS-1:0]   w_illegal;
    logic [NUM_LEGS-1:0]   w_stretch;
    logic [2*NUM_LEGS-1:0] w_leg_gate;
    logic                  w_any_illegal, w_kill, w_clear, w_buck_up;
    logic                  r_fault;
    logic [NUM_LEGS-1:0]   r_fault_leg;
    logic [15:0]           r_stretch_cnt;
    logic [2:0]            w_stretch_sum;
    logic [16:0]           w_stretch_acc;
    deion_state_t          r_deion, w_deion_nxt;
    logic [CNT_W-1:0]      r_deion_cnt, w_deion_cnt_nxt;

    for (genvar gi = 0; gi < NUM_LEGS; gi++) begin : g_leg
        assign w_illegal[gi] = (bus.leg_req[2*gi +: 2] == GATE_ILLEGAL);

        gate_leg_guard #(
            .DEAD_TIME (DEAD_TIME),
            .MIN_ON    (MIN_ON),
            .CNT_W     (CNT_W)
        ) u_leg (
            .clk     (clk),
            .rst     (rst),
            .req     (bus.leg_req[2*gi +: 2]),
            .kill    (w_kill),
            .restart (w_clear),
            .gate    (w_leg_gate[2*gi +: 2]),
            .stretch (w_stretch[gi])
        );
    end

    assign w_any_illegal = |w_illegal;
    assign w_kill        = !bus.gate_en || r_fault || w_any_illegal;
    // Clearing needs an idle request set so every leg restarts from OFF.
    assign w_clear       = bus.fault_clear && r_fault &&
                           (bus.leg_req == '0) && !bus.deion_req;

    // Deion may not come on while either buck upper switch is on or asked for.
    assign w_buck_up = bus.leg_req[2*LEG_BUCK1+1] | bus.leg_req[2*LEG_BUCK2+1] |
                       w_leg_gate[2*LEG_BUCK1+1]  | w_leg_gate[2*LEG_BUCK2+1];

    always_comb begin
        w_deion_nxt = r_deion;
        case (r_deion)
            DEION_OFF: if (bus.deion_req && !w_buck_up &&
                           (r_deion_cnt >= c_min_off_m1)) w_deion_nxt = DEION_ON;
            DEION_ON:  if (!bus.deion_req &&
                           (r_deion_cnt >= c_min_on_m1))  w_deion_nxt = DEION_OFF;
            default:   w_deion_nxt = DEION_OFF;
        endcase
        if (w_kill) w_deion_nxt = DEION_OFF;
        w_deion_cnt_nxt = (r_deion_cnt == c_cnt_max) ? r_deion_cnt : r_deion_cnt + 1'b1;
        if (w_deion_nxt != r_deion) w_deion_cnt_nxt = '0;
    end

    always_comb begin
        w_stretch_sum = '0;
        for (int i = 0; i < NUM_LEGS; i++) begin
            w_stretch_sum = w_stretch_sum + 3'(w_stretch[i]);
        end
        w_stretch_acc = {1'b0, r_stretch_cnt} + 17'(w_stretch_sum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault       <= 1'b0;
            r_fault_leg   <= '0;
            r_stretch_cnt <= '0;
            r_deion       <= DEION_OFF;
            r_deion_cnt   <= c_cnt_max;
        end else begin
            // A new 2'b11 wins over a clear arriving in the same cycle.
            r_fault       <= w_any_illegal | (r_fault & ~w_clear);
            r_fault_leg   <= r_fault_leg | w_illegal;
            r_stretch_cnt <= w_stretch_acc[16] ? 16'hFFFF : w_stretch_acc[15:0];
            r_deion       <= w_deion_nxt;
            r_deion_cnt   <= w_deion_cnt_nxt;
        end
    end

    assign bus.leg_gate    = w_leg_gate;
    assign bus.deion_gate  = (r_deion == DEION_ON);
    assign bus.fault       = r_fault;
    assign bus.fault_leg   = r_fault_leg;
    assign bus.stretch_cnt = r_stretch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mos_gate_guard.sv
`default_nettype none
// ============================================================================
// Module  : tb_mos_gate_guard
// Purpose : Self-checking bench for mos_gate_guard. Directed scenarios plus
//           randomized traffic, compared every cycle against a timestamp-based
//           reference model of the guard rules.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mos_gate_guard;

    localparam int DEAD_TIME = 10;
    localparam int MIN_ON    = 5;
    localparam int MIN_OFF   = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mos_gate_guard_if bus();

    mos_gate_guard dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus for the next cycle
    logic       s_rst = 1'b0;
    logic       s_gate_en = 1'b1;
    logic [7:0] s_leg_req = 8'h00;
    logic       s_deion_req = 1'b0;
    logic       s_fault_clear = 1'b0;

    // reference model: each switch remembers when it entered its current
    // level; rules are elapsed-time comparisons against the limits
    longint     m_n = 0;
    logic [1:0] m_out [4];
    longint     m_t [4];
    logic [1:0] m_prev [4];
    logic       m_counted [4];
    logic       m_fault, m_deion;
    longint     m_deion_t;
    logic [3:0] m_fault_leg;
    int         m_stretch;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] ill;
        logic       kill, clr, bup, want, ok, is_edge, d_next;
        logic [1:0] r, tgt;
        longint     el;
        int         inc;
        if (s_rst) begin
            for (int i = 0; i < 4; i++) begin
                m_out[i] = 2'b00; m_t[i] = -1000000; m_prev[i] = 2'b00; m_counted[i] = 1'b0;
            end
            m_fault = 1'b0; m_fault_leg = 4'h0; m_stretch = 0;
            m_deion = 1'b0; m_deion_t = -1000000;
        end else begin
            for (int i = 0; i < 4; i++) ill[i] = (s_leg_req[2*i +: 2] == 2'b11);
            kill = !s_gate_en || m_fault || (ill != 4'h0);
            clr  = s_fault_clear && m_fault && (s_leg_req == 8'h00) && !s_deion_req;

            bup = s_leg_req[7] || s_leg_req[5] || (m_out[3] == 2'b10) || (m_out[2] == 2'b10);
            el = m_n - m_deion_t;
            d_next = m_deion;
            if (kill) d_next = 1'b0;
            else if (!m_deion && s_deion_req && !bup && el >= MIN_OFF - 1) d_next = 1'b1;
            else if (m_deion && !s_deion_req && el >= MIN_ON - 1) d_next = 1'b0;
            if (d_next != m_deion) begin m_deion = d_next; m_deion_t = m_n + 1; end

            inc = 0;
            for (int i = 0; i < 4; i++) begin
                r  = s_leg_req[2*i +: 2];
                el = m_n - m_t[i];
                if (m_out[i] == 2'b00) begin
                    want = (r == 2'b10) || (r == 2'b01);
                    ok   = el >= DEAD_TIME - 1;
                end else begin
                    want = (r != m_out[i]);
                    ok   = el >= MIN_ON - 1;
                end
                tgt = m_out[i];
                if (kill) tgt = 2'b00;
                else if (want && ok) tgt = (m_out[i] == 2'b00) ? r : 2'b00;
                is_edge = (r != m_prev[i]);
                if (!kill && want && !ok && (is_edge || !m_counted[i])) begin
                    inc++; m_counted[i] = 1'b1;
                end else if (is_edge) begin
                    m_counted[i] = 1'b0;
                end
                m_prev[i] = r;
                if (tgt != m_out[i]) begin m_out[i] = tgt; m_t[i] = m_n + 1; end
                if (clr) m_t[i] = m_n + 1;
            end
            m_fault_leg = m_fault_leg | ill;
            m_fault = (ill != 4'h0) ? 1'b1 : (clr ? 1'b0 : m_fault);
            m_stretch = (m_stretch + inc > 65535) ? 65535 : m_stretch + inc;
        end
        m_n++;
    endtask

    // apply stimulus, let one edge pass, compare every output with the model
    task automatic tick();
        rst             = s_rst;
        bus.gate_en     = s_gate_en;
        bus.leg_req     = s_leg_req;
        bus.deion_req   = s_deion_req;
        bus.fault_clear = s_fault_clear;
        model_step();
        @(posedge clk);
        #1;
        check_eq("leg_gate",    32'(bus.leg_gate),    32'({m_out[3], m_out[2], m_out[1], m_out[0]}));
        check_eq("deion_gate",  32'(bus.deion_gate),  32'(m_deion));
        check_eq("fault",       32'(bus.fault),       32'(m_fault));
        check_eq("fault_leg",   32'(bus.fault_leg),   32'(m_fault_leg));
        check_eq("stretch_cnt", 32'(bus.stretch_cnt), 32'(m_stretch));
    endtask

    task automatic do_reset();
        s_rst = 1'b1; s_gate_en = 1'b1; s_leg_req = 8'h00;
        s_deion_req = 1'b0; s_fault_clear = 1'b0;
        tick();
        s_rst = 1'b0;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_up, n_off, k, lg, c;
        logic [1:0] g;

        // 1: reset state, then a single turn-on with one cycle latency
        do_reset();
        check_eq("rst_leg_gate", 32'(bus.leg_gate), 32'h0);
        check_eq("rst_fault", 32'(bus.fault), 32'h0);
        check_eq("rst_stretch", 32'(bus.stretch_cnt), 32'h0);
        s_leg_req = 8'b10_00_00_00;
        tick();
        check_eq("t1_gate", 32'(bus.leg_gate), 32'h80);
        check_eq("t1_stretch", 32'(bus.stretch_cnt), 32'h0);

        // 2: buck1 10 then 01 the next cycle
        do_reset();
        s_leg_req = 8'b10_00_00_00;
        tick();
        n_up = (bus.leg_gate[7:6] == 2'b10) ? 1 : 0;
        n_off = 0;
        g = 2'b00;
        s_leg_req = 8'b01_00_00_00;
        for (int i = 0; i < 40; i++) begin
            tick();
            g = bus.leg_gate[7:6];
            if (g == 2'b10) n_up++;
            else if (g == 2'b00) n_off++;
            else break;
        end
        check_eq("t2_on_cycles", 32'(n_up), 32'(MIN_ON));
        check_eq("t2_dead_cycles", 32'(n_off), 32'(DEAD_TIME));
        check_eq("t2_final", 32'(g), 32'h1);
        check_eq("t2_stretch", 32'(bus.stretch_cnt), 32'h1);

        // 3: short res1 pulse is stretched to MIN_ON
        do_reset();
        s_leg_req = 8'b00_00_10_00;
        n_up = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus.leg_gate[3:2] == 2'b10) n_up++;
        end
        s_leg_req = 8'h00;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.leg_gate[3:2] == 2'b10) n_up++;
            else break;
        end
        check_eq("t3_on_cycles", 32'(n_up), 32'(MIN_ON));
        check_eq("t3_off", 32'(bus.leg_gate[3:2]), 32'h0);

        // 4: illegal buck2 request, refused and accepted clears
        do_reset();
        s_leg_req = 8'b10_00_00_00;
        tick();
        s_leg_req = 8'b10_11_00_00;
        tick();
        check_eq("t4_kill_gate", 32'(bus.leg_gate), 32'h0);
        check_eq("t4_fault", 32'(bus.fault), 32'h1);
        check_eq("t4_fault_leg", 32'(bus.fault_leg), 32'h4);
        s_leg_req = 8'b10_00_00_00; s_fault_clear = 1'b1;
        tick();
        check_eq("t4_clear_refused", 32'(bus.fault), 32'h1);
        s_leg_req = 8'h00;
        tick();
        s_fault_clear = 1'b0;
        check_eq("t4_clear_ok", 32'(bus.fault), 32'h0);
        s_leg_req = 8'b10_00_00_00;
        k = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            k++;
            if (bus.leg_gate[7:6] == 2'b10) break;
        end
        check_eq("t4_restart_delay", 32'(k), 32'(DEAD_TIME));
        check_eq("t4_fault_leg_kept", 32'(bus.fault_leg), 32'h4);

        // 5: deion interlock against buck1 upper
        do_reset();
        s_leg_req = 8'b10_00_00_00; s_deion_req = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_eq("t5_deion_blocked", 32'(bus.deion_gate), 32'h0);
        s_leg_req = 8'b01_00_00_00;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.leg_gate[7:6] == 2'b01) break;
        end
        check_eq("t5_buck1_lo", 32'(bus.leg_gate[7:6]), 32'h1);
        check_eq("t5_deion_on", 32'(bus.deion_gate), 32'h1);

        // 6: gate_en drop mid pulse, then reset mid pulse
        do_reset();
        s_leg_req = 8'b00_00_00_10;
        tick();
        tick();
        s_gate_en = 1'b0;
        tick();
        check_eq("t6_gate_en_kill", 32'(bus.leg_gate), 32'h0);
        check_eq("t6_no_fault", 32'(bus.fault), 32'h0);
        s_gate_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.leg_gate[1:0] == 2'b10) break;
        end
        check_eq("t6_reenabled", 32'(bus.leg_gate[1:0]), 32'h2);
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        check_eq("t6_rst_gate", 32'(bus.leg_gate), 32'h0);
        check_eq("t6_rst_stretch", 32'(bus.stretch_cnt), 32'h0);

        // randomized traffic
        do_reset();
        for (c = 0; c < 3000; c++) begin
            s_fault_clear = 1'b0;
            s_rst = ($urandom_range(0, 599) == 0);
            s_gate_en = ($urandom_range(0, 39) != 0);
            for (int i = 0; i < 4; i++) begin
                if (s_leg_req[2*i +: 2] == 2'b11) s_leg_req[2*i +: 2] = 2'b00;
            end
            if ($urandom_range(0, 4) == 0) begin
                lg = int'($urandom_range(0, 3));
                k  = int'($urandom_range(0, 2));
                s_leg_req[2*lg +: 2] = (k == 0) ? 2'b00 : ((k == 1) ? 2'b10 : 2'b01);
            end
            if ($urandom_range(0, 99) == 0) begin
                lg = int'($urandom_range(0, 3));
                s_leg_req[2*lg +: 2] = 2'b11;
            end
            if ($urandom_range(0, 7) == 0) s_deion_req = ~s_deion_req;
            if ($urandom_range(0, 5) == 0) begin
                s_fault_clear = 1'b1;
                if (m_fault && $urandom_range(0, 3) != 0) begin
                    s_leg_req = 8'h00; s_deion_req = 1'b0;
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
